// File: rtl/apb_master.sv
// Single-outstanding APB master: valid/ready command in, one response pulse out.
// Includes a wait-state timeout and a saturating error counter.
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response side
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [15:0]       err_count,
    // APB side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam int unsigned ERR_W   = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              cmd_ready_nxt;
    logic              psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;
    logic [ERR_W-1:0]  err_count_nxt;
    logic              err_inc;

    // State and every output register; reset forces IDLE with the bus quiet.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            cmd_ready   <= cmd_ready_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            paddr       <= paddr_nxt;
            pwdata      <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            err_count   <= err_count_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        cmd_ready_nxt   = cmd_ready;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        paddr_nxt       = paddr;
        pwdata_nxt      = pwdata;
        rsp_valid_nxt   = 1'b0;
        rsp_rdata_nxt   = '0;
        rsp_err_nxt     = 1'b0;
        rsp_timeout_nxt = 1'b0;
        err_inc         = 1'b0;

        case (state)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                psel_nxt      = 1'b0;
                penable_nxt   = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    state_nxt     = SETUP;
                    cmd_ready_nxt = 1'b0;
                    psel_nxt      = 1'b1;
                    pwrite_nxt    = cmd_write;
                    paddr_nxt     = cmd_addr;
                    pwdata_nxt    = cmd_wdata;
                end
            end
            SETUP: begin
                state_nxt    = ACCESS;
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
            end
            ACCESS: begin
                // Completion takes priority over a timeout in the same cycle.
                if (pready) begin
                    state_nxt     = IDLE;
                    cmd_ready_nxt = 1'b1;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = pwrite ? '0 : prdata;
                    rsp_err_nxt   = pslverr;
                    err_inc       = pslverr;
                end else if (TO_EN && (wait_cnt == CNT_W'(TO_LAST))) begin
                    state_nxt       = IDLE;
                    cmd_ready_nxt   = 1'b1;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    err_inc         = 1'b1;
                    wait_cnt_nxt    = wait_cnt + CNT_W'(1);
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt     = IDLE;
                cmd_ready_nxt = 1'b0;
                psel_nxt      = 1'b0;
                penable_nxt   = 1'b0;
            end
        endcase
    end

    // Saturating error counter, updated alongside the erroring response.
    always_comb begin
        err_count_nxt = err_count;
        if (err_inc && (err_count != {ERR_W{1'b1}})) begin
            err_count_nxt = err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: transfer timing, wait states, errors,
// timeout boundary, back-to-back throughput and reset during ACCESS.
module tb_apb_master;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [15:0] err_count;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp;
    int n_bad;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .err_count(err_count),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        tick();
        tick();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
        n_cmp++; if ({psel, penable, pwrite, rsp_valid} !== 4'b0) begin n_bad++; $display("FAIL rst_ctrl got %b exp 0000", {psel, penable, pwrite, rsp_valid}); end
        n_cmp++; if (paddr !== 32'h0 || pwdata !== 32'h0) begin n_bad++; $display("FAIL rst_addr_data got %h/%h exp 0/0", paddr, pwdata); end
        n_cmp++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL rst_err_count got %h exp 0", err_count); end
        presetn = 1'b1;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic test_zero_wait_write();
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'hFFFF_FFFF;
        issue(1'b1, 32'h104, 32'hA5A5_A5A5);
        tick(); // cycle 1
        cmd_valid = 1'b0;
        n_cmp++; if ({psel, penable, cmd_ready} !== 3'b100) begin n_bad++; $display("FAIL wr_setup got %b exp 100", {psel, penable, cmd_ready}); end
        n_cmp++; if (pwrite !== 1'b1 || paddr !== 32'h104 || pwdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL wr_setup_bus got %b %h %h", pwrite, paddr, pwdata); end
        tick(); // cycle 2
        n_cmp++; if ({psel, penable} !== 2'b11 || pwdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL wr_access got %b %h exp 11 a5a5a5a5", {psel, penable}, pwdata); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_early_rsp got %b exp 0", rsp_valid); end
        tick(); // cycle 3
        n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready} !== 4'b1001) begin n_bad++; $display("FAIL wr_rsp got %b exp 1001", {rsp_valid, rsp_err, rsp_timeout, cmd_ready}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata got %h exp 0", rsp_rdata); end
        n_cmp++; if ({psel, penable} !== 2'b00) begin n_bad++; $display("FAIL wr_idle got %b exp 00", {psel, penable}); end
        tick(); // cycle 4
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_pulse got %b exp 0", rsp_valid); end
        n_cmp++; if (pwdata !== 32'hA5A5_A5A5 || paddr !== 32'h104) begin n_bad++; $display("FAIL wr_hold got %h %h exp 104 a5a5a5a5", paddr, pwdata); end
    endtask

    task automatic test_wait_read();
        pready = 1'b0;
        prdata = 32'h0;
        issue(1'b0, 32'h204, 32'h0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            cmd_valid = 1'b0;
            n_cmp++; if (paddr !== 32'h204 || psel !== 1'b1) begin n_bad++; $display("FAIL rd_paddr_c%0d got %h psel %b exp 204 1", c, paddr, psel); end
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_early_rsp_c%0d got %b exp 0", c, rsp_valid); end
            if (c == 5) begin
                pready = 1'b1;
                prdata = 32'h1234_5678;
            end
        end
        tick(); // cycle 6
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_rsp got %b%b exp 10", rsp_valid, rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_rdata got %h exp 12345678", rsp_rdata); end
        tick();
    endtask

    task automatic test_slverr();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_DEAD;
        issue(1'b0, 32'h1000, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick(); // cycle 3
        n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin n_bad++; $display("FAIL se_rsp got %b exp 110", {rsp_valid, rsp_err, rsp_timeout}); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_DEAD) begin n_bad++; $display("FAIL se_rdata got %h exp deaddead", rsp_rdata); end
        pslverr = 1'b0;
        tick();
        n_cmp++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL se_err_count got %0d exp 1", err_count); end
    endtask

    task automatic test_timeout();
        int access_cycles;
        access_cycles = 0;
        pready = 1'b0;
        prdata = 32'h5555_5555;
        issue(1'b0, 32'h400, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            tick();
            cmd_valid = 1'b0;
            if (penable) access_cycles++;
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL to_early_rsp_c%0d got %b exp 0", c, rsp_valid); end
        end
        n_cmp++; if (access_cycles !== 16) begin n_bad++; $display("FAIL to_access_len got %0d exp 16", access_cycles); end
        tick(); // cycle 18
        n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111) begin n_bad++; $display("FAIL to_rsp got %b exp 111", {rsp_valid, rsp_err, rsp_timeout}); end
        n_cmp++; if (rsp_rdata !== 32'h0 || {psel, penable} !== 2'b00) begin n_bad++; $display("FAIL to_bus got %h %b exp 0 00", rsp_rdata, {psel, penable}); end
        tick();
        n_cmp++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL to_err_count got %0d exp 2", err_count); end
    endtask

    task automatic test_timeout_boundary();
        pready = 1'b0;
        issue(1'b0, 32'h408, 32'h0);
        for (int c = 1; c <= 17; c++) begin
            tick();
            cmd_valid = 1'b0;
            if (c == 17) begin
                pready = 1'b1;
                prdata = 32'hCAFE_F00D;
            end
        end
        n_cmp++; if (penable !== 1'b1) begin n_bad++; $display("FAIL tb_still_access got %b exp 1", penable); end
        tick(); // cycle 18
        n_cmp++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100) begin n_bad++; $display("FAIL tb_rsp got %b exp 100", {rsp_valid, rsp_err, rsp_timeout}); end
        n_cmp++; if (rsp_rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL tb_rdata got %h exp cafef00d", rsp_rdata); end
        tick();
        n_cmp++; if (err_count !== 16'd2) begin n_bad++; $display("FAIL tb_err_count got %0d exp 2", err_count); end
    endtask

    task automatic test_back_to_back();
        int  n_acc;
        int  n_rsp;
        bit  acc;
        bit  exp_rv;
        n_acc  = 0;
        n_rsp  = 0;
        pready = 1'b1;
        issue(1'b1, 32'h300, 32'h1111_0000);
        for (int cyc = 0; cyc <= 13; cyc++) begin
            exp_rv = (cyc == 3) || (cyc == 6) || (cyc == 9) || (cyc == 12);
            n_cmp++; if (rsp_valid !== exp_rv) begin n_bad++; $display("FAIL b2b_rsp_c%0d got %b exp %b", cyc, rsp_valid, exp_rv); end
            if (rsp_valid) n_rsp++;
            if (cyc % 3 == 1 && cyc <= 10) begin
                n_cmp++; if (paddr !== 32'h300 + 32'(4 * (cyc / 3))) begin n_bad++; $display("FAIL b2b_paddr_c%0d got %h exp %h", cyc, paddr, 32'h300 + 32'(4 * (cyc / 3))); end
            end
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                n_cmp++; if (cyc !== n_acc * 3) begin n_bad++; $display("FAIL b2b_accept got cycle %0d exp %0d", cyc, n_acc * 3); end
                n_acc++;
            end
            tick();
            if (acc) begin
                if (n_acc == 4) cmd_valid = 1'b0;
                else begin
                    cmd_addr  = 32'h300 + 32'(4 * n_acc);
                    cmd_wdata = 32'h1111_0000 + 32'(n_acc);
                end
            end
        end
        n_cmp++; if (n_acc !== 4 || n_rsp !== 4) begin n_bad++; $display("FAIL b2b_counts got acc %0d rsp %0d exp 4 4", n_acc, n_rsp); end
    endtask

    task automatic test_reset_in_access();
        pready = 1'b0;
        issue(1'b1, 32'h500, 32'h7777_7777);
        tick();
        cmd_valid = 1'b0;
        tick(); // cycle 2, ACCESS
        n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL ra_in_access got %b exp 11", {psel, penable}); end
        presetn = 1'b0;
        #1;
        n_cmp++; if ({psel, penable, cmd_ready} !== 3'b000) begin n_bad++; $display("FAIL ra_async got %b exp 000", {psel, penable, cmd_ready}); end
        n_cmp++; if (err_count !== 16'd0 || paddr !== 32'h0) begin n_bad++; $display("FAIL ra_clear got %0d %h exp 0 0", err_count, paddr); end
        tick();
        presetn = 1'b1;
        pready  = 1'b1;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ra_release_ready got %b exp 1", cmd_ready); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (rsp_valid !== 1'b0 || psel !== 1'b0) begin n_bad++; $display("FAIL ra_no_rsp_c%0d got %b %b exp 0 0", c, rsp_valid, psel); end
            tick();
        end
        n_cmp++; if (err_count !== 16'd0) begin n_bad++; $display("FAIL ra_err_count got %0d exp 0", err_count); end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_in_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers, and returns one response per command. Sits directly upstream of the APB address-decode interconnect and drives its psel/penable/pwrite/paddr/pwdata inputs, consuming its prdata/pready/pslverr. Adds a wait-state timeout so a hung slave cannot stall the bus indefinitely, and keeps a saturating error count.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max ACCESS cycles with pready=0 before abort; 0 disables timeout
- pclk  in  1  clock; all logic rising-edge
- presetn  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  pslverr seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- err_count  out  16  saturating count of rsp_err responses
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W, pwdata  out  DATA_W  APB address/data
- prdata  in  DATA_W, pready  in  1, pslverr  in  1  APB response

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, go SETUP.
- SETUP: psel=1, penable=0, cmd_ready=0; unconditionally go ACCESS; clear wait counter.
- ACCESS: psel=1, penable=1. pwrite/paddr/pwdata stable from SETUP until return to IDLE.
  - pready=1: rsp_valid=1 next cycle; rsp_rdata=prdata if read else 0; rsp_err=pslverr; rsp_timeout=0; go IDLE.
  - pready=0: increment wait counter (width clog2(TIMEOUT+1)). When TIMEOUT!=0 and counter reaches TIMEOUT: abort, go IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- pready/pslverr/prdata ignored outside ACCESS.
- err_count increments on every rsp_valid with rsp_err=1; saturates at 16'hFFFF.
- paddr/pwrite/pwdata keep last value in IDLE (not cleared).
- No response backpressure; rsp_valid is a single-cycle pulse, one per accepted command.
- Reset (presetn low, any state): immediately state=IDLE, psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, err_count=0, wait counter=0; cmd_ready=0 while presetn low, 1 in first cycle after release. Aborted transfer produces no response.

## Timing
- Command accepted at edge 0 -> psel=1 in cycle 1 (SETUP) -> penable=1 in cycle 2 (ACCESS).
- Zero-wait slave: pready=1 in cycle 2 -> rsp_valid and cmd_ready both high in cycle 3.
- N wait states: rsp_valid in cycle 3+N.
- Back-to-back commands: one transfer every 3 cycles minimum; new command accepted in the same cycle rsp_valid is high.
- Timeout: with pready held 0, psel/penable drop and rsp_valid rises in cycle 2+TIMEOUT; ACCESS lasts exactly TIMEOUT cycles.
- pready=1 on the same cycle the counter would reach TIMEOUT: completion wins, rsp_timeout=0.

## Test plan
- Zero-wait write addr 0x104 data 0xA5A5A5A5 -> psel cycle 1, penable cycle 2, pwdata=0xA5A5A5A5 stable, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read addr 0x204 with slave inserting 3 wait states returning 0x12345678 -> rsp_valid cycle 6, rsp_rdata=0x12345678, paddr stable cycles 1-5.
- Read addr 0x1000 (undecoded; interconnect returns pready=1, pslverr=1, prdata=0xDEADDEAD) -> rsp_err=1, rsp_rdata=0xDEADDEAD, err_count=1.
- TIMEOUT=16, pready stuck 0 -> ACCESS for 16 cycles, rsp_valid cycle 18 with rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready=1 exactly on 16th cycle -> normal completion, rsp_timeout=0.
- cmd_valid held high with 4 commands, zero-wait slave -> accepts at cycles 0,3,6,9; four rsp_valid pulses at cycles 3,6,9,12.
- presetn asserted during ACCESS -> psel/penable 0 immediately, no rsp_valid, err_count=0, cmd_ready=1 in first cycle after release.
